lsu_seq: RTL

Load/store sequencer between the core's execute stage and the data-memory port. Accepts one load or store per request using the decoder's `loadops`/`storeops` encodings, drives a req/ack memory handshake with byte enables, aligns and extends load data, and stalls the core until the access completes. A watchdog converts a missing acknowledge into an error response.

---
 rtl/lsu_seq_pkg.sv | 30 +++
 rtl/lsu_seq_align.sv | 80 ++++++++
 rtl/lsu_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_seq_pkg.sv
// lsu_seq_pkg: shared constants for the load/store sequencer.
//   - Load funct3 codes (LD_LB/LH/LW/LBU/LHU) and the NO_LOAD marker.
//   - Store op codes (STORE_NONE/B/H/W).
//   - FSM state encoding (LSU_IDLE, LSU_ACCESS, LSU_RESP).
//   - has_op(): true when a request carries a load or a store.
package lsu_seq_pkg;

   localparam logic [2:0] LD_LB   = 3'd0;
   localparam logic [2:0] LD_LH   = 3'd1;
   localparam logic [2:0] LD_LW   = 3'd2;
   localparam logic [2:0] LD_LBU  = 3'd4;
   localparam logic [2:0] LD_LHU  = 3'd5;
   localparam logic [2:0] NO_LOAD = 3'd7;

   localparam logic [1:0] STORE_NONE = 2'd0;
   localparam logic [1:0] STORE_B    = 2'd1;
   localparam logic [1:0] STORE_H    = 2'd2;
   localparam logic [1:0] STORE_W    = 2'd3;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_RESP   = 2'd2
   } lsu_state_t;

   function automatic logic has_op(input logic [2:0] ld, input logic [1:0] st);
      return (st != STORE_NONE) || (ld != NO_LOAD);
   endfunction

endpackage

// File: rtl/lsu_seq_align.sv
// lsu_align: combinational lane steering for lsu_seq.
//   Inputs : loadops/storeops (op codes), offset (byte offset addr[1:0]),
//            wdata (store data in low bits), word (read word from memory).
//   Outputs: be (byte enables), wdata_lane (lane-replicated store data),
//            ld_data (aligned, sign/zero-extended load result; 0 when no
//            load), misaligned (only ever set when LSU_MISALIGN_TRAP_EN is
//            defined).
// Callers pass loadops = NO_LOAD when a store is present, so a store never
// produces load data.
module lsu_align
   import lsu_seq_pkg::*;
(
   input  logic [2:0]  loadops,
   input  logic [1:0]  storeops,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] word,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] ld_data,
   output logic        misaligned
);

   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halfword accesses only look at addr[1]; addr[0] is ignored unless trapped.
   assign byte_shift = word >> {offset, 3'b000};
   assign half_shift = word >> {offset[1], 4'b0000};
   assign byte_sel   = byte_shift[7:0];
   assign half_sel   = half_shift[15:0];

   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      case (storeops)
         STORE_B: begin
            be         = 4'b0001 << offset;
            wdata_lane = {4{wdata[7:0]}};
         end
         STORE_H: begin
            be         = offset[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: begin
            be         = 4'b1111;
            wdata_lane = wdata;
         end
      endcase
   end

   always_comb begin
      ld_data = 32'd0;
      case (loadops)
         LD_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  ld_data = {24'd0, byte_sel};
         LD_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  ld_data = {16'd0, half_sel};
         NO_LOAD: ld_data = 32'd0;
         default: ld_data = word;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic is_half;
   logic is_word;
   always_comb begin
      is_half = (storeops == STORE_H) ||
                ((storeops == STORE_NONE) && ((loadops == LD_LH) || (loadops == LD_LHU)));
      is_word = (storeops == STORE_W) ||
                ((storeops == STORE_NONE) && (loadops == LD_LW));
      misaligned = (is_half && offset[0]) || (is_word && (offset != 2'b00));
   end
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between execute stage and data memory.
//   Parameter TIMEOUT_CYC (>=1): unacknowledged cycles before abort with err.
//   Core side : req_valid, loadops, storeops, addr, wdata in;
//               stall, done, rdata, err out.
//   Memory    : mem_req, mem_we, mem_be, mem_addr, mem_wdata out;
//               mem_ack, mem_rdata in.
//   Clock/reset: clk (rising edge), rst (synchronous, active high).
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete immediately with err=1 and never reach memory.
module lsu_seq
   import lsu_seq_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [2:0]  loadops,
   input  logic [1:0]  storeops,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   lsu_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  ld_op_q, ld_op_d;
   logic [1:0]  off_q, off_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        in_idle;
   logic [2:0]  req_ld;
   logic        accept;
   logic        expire;
   logic [2:0]  al_ld;
   logic [1:0]  al_st;
   logic [1:0]  al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_ld_data;
   logic        al_misaligned;

   assign in_idle = (state_q == LSU_IDLE);
   // A store suppresses any load presented alongside it.
   assign req_ld  = (storeops != STORE_NONE) ? NO_LOAD : loadops;
   assign accept  = in_idle && req_valid && has_op(loadops, storeops);
   // cnt_q counts unacknowledged cycles already spent; the current cycle is
   // the TIMEOUT_CYC-th when cnt_q reaches TIMEOUT_CYC-1.
   assign expire  = (cnt_q == CW'(TIMEOUT_CYC - 1));

   // In IDLE the aligner steers the incoming request; in ACCESS it extends
   // the returning word using the latched load op and offset.
   assign al_ld  = in_idle ? req_ld    : ld_op_q;
   assign al_st  = in_idle ? storeops  : STORE_NONE;
   assign al_off = in_idle ? addr[1:0] : off_q;

   lsu_align u_align (
      .loadops    (al_ld),
      .storeops   (al_st),
      .offset     (al_off),
      .wdata      (wdata),
      .word       (mem_rdata),
      .be         (al_be),
      .wdata_lane (al_wdata),
      .ld_data    (al_ld_data),
      .misaligned (al_misaligned)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_op_d     = ld_op_q;
      off_d       = off_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         LSU_IDLE: begin
            if (accept) begin
               if (al_misaligned) begin
                  state_d = LSU_RESP;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end else begin
                  state_d     = LSU_ACCESS;
                  cnt_d       = '0;
                  ld_op_d     = req_ld;
                  off_d       = addr[1:0];
                  mem_req_d   = 1'b1;
                  mem_we_d    = (storeops != STORE_NONE);
                  mem_be_d    = al_be;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = al_wdata;
               end
            end
         end
         LSU_ACCESS: begin
            // Ack is checked first so it wins over a simultaneous expiry.
            if (mem_ack) begin
               state_d   = LSU_RESP;
               done_d    = 1'b1;
               rdata_d   = al_ld_data;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end else if (expire) begin
               state_d   = LSU_RESP;
               done_d    = 1'b1;
               err_d     = 1'b1;
               rdata_d   = 32'd0;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LSU_IDLE;
         cnt_q       <= '0;
         ld_op_q     <= NO_LOAD;
         off_q       <= 2'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ld_op_q     <= ld_op_d;
         off_q       <= off_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign stall     = accept || (state_q == LSU_ACCESS);
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
